// File: rtl/bram_b_arbiter_if.sv
// bram_b_arbiter_if: requester, port B and read-return signals of the port B arbiter
interface bram_b_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [2:0]        req;
    logic [2:0]        lock;
    logic [2:0]        we_req;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [ADDR_W-1:0] addr2;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic [DATA_W-1:0] wdata2;
    logic [2:0]        gnt;
    logic [2:0]        rvalid;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] data_b;
    logic              we_b;
    logic [DATA_W-1:0] q_b;
    logic              busy;

    modport master (
        output req, lock, we_req, addr0, addr1, addr2, wdata0, wdata1, wdata2, q_b,
        input  gnt, rvalid, rdata, addr_b, data_b, we_b, busy
    );

    modport slave (
        input  req, lock, we_req, addr0, addr1, addr2, wdata0, wdata1, wdata2, q_b,
        output gnt, rvalid, rdata, addr_b, data_b, we_b, busy
    );
endinterface

// File: rtl/bram_b_arbiter.sv
// bram_b_arbiter: round-robin arbiter with per-requester lock sharing BRAM port B among three requesters
module bram_b_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input logic             clk_i,
    input logic             rst_ni,
    bram_b_arbiter_if.slave bus
);
    logic [1:0]        last_q;
    logic [2:0]        req_m;
    logic [1:0]        p0;
    logic [1:0]        p1;
    logic [1:0]        win;
    logic              any;
    logic [ADDR_W-1:0] addr_b_q;
    logic [DATA_W-1:0] data_b_q;
    logic              we_b_q;
    logic              iss_v_q;
    logic              iss_rd_q;
    logic [1:0]        iss_own_q;
    logic              ret_v_q;
    logic              ret_rd_q;
    logic [1:0]        ret_own_q;

    // requests are ignored while reset is held so gnt stays low
    assign req_m = rst_ni ? bus.req : 3'b000;
    assign any   = |req_m;

    // round-robin order after the last owner; the last owner itself comes third
    assign p0  = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;
    assign p1  = (p0 == 2'd2) ? 2'd0 : p0 + 2'd1;
    assign win = (bus.lock[last_q] && req_m[last_q]) ? last_q :
                 req_m[p0] ? p0 : req_m[p1] ? p1 : last_q;

    assign bus.gnt    = any ? (3'b001 << win) : 3'b000;
    assign bus.addr_b = addr_b_q;
    assign bus.data_b = data_b_q;
    assign bus.we_b   = we_b_q;
    assign bus.rvalid = (ret_v_q && ret_rd_q) ? (3'b001 << ret_own_q) : 3'b000;
    assign bus.rdata  = (|bus.rvalid) ? bus.q_b : '0;
    assign bus.busy   = iss_v_q | ret_v_q;

    // issue the winner onto port B and track the read through issue and return stages
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q    <= 2'd2;
            addr_b_q  <= '0;
            data_b_q  <= '0;
            we_b_q    <= 1'b0;
            iss_v_q   <= 1'b0;
            iss_rd_q  <= 1'b0;
            iss_own_q <= 2'd0;
            ret_v_q   <= 1'b0;
            ret_rd_q  <= 1'b0;
            ret_own_q <= 2'd0;
        end else begin
            if (any) begin
                last_q    <= win;
                addr_b_q  <= (win == 2'd0) ? bus.addr0 : (win == 2'd1) ? bus.addr1 : bus.addr2;
                data_b_q  <= (win == 2'd0) ? bus.wdata0 : (win == 2'd1) ? bus.wdata1 : bus.wdata2;
                we_b_q    <= bus.we_req[win];
                iss_v_q   <= 1'b1;
                iss_rd_q  <= ~bus.we_req[win];
                iss_own_q <= win;
            end else begin
                we_b_q  <= 1'b0;
                iss_v_q <= 1'b0;
            end
            ret_v_q   <= iss_v_q;
            ret_rd_q  <= iss_rd_q;
            ret_own_q <= iss_own_q;
        end
    end
endmodule
